// File: rtl/shade_pkg.sv
// Shared fixed-point types, constants and the multiply helper for the reflect pipe.
// No state; multiply wraps to TOTAL_PREC after the FRAC_BITS arithmetic shift.
package shade_pkg;
    localparam int TOTAL_PREC   = 27;
    localparam int FRAC_BITS    = 22;
    localparam int OUT_BITS_DEF = 8;
    localparam int TAG_W_DEF    = 16;

    typedef logic signed [TOTAL_PREC-1:0]   fx_t;
    typedef logic signed [2*TOTAL_PREC-1:0] fx2_t;
    // Component 0 = x, 1 = y, 2 = z.
    typedef fx_t [2:0] vec3_t;

    localparam fx_t   FX_ONE        = fx_t'(1 << FRAC_BITS);
    localparam vec3_t DEFAULT_LIGHT = {fx_t'(0), FX_ONE, fx_t'(0)};

    function automatic fx_t fx_mul(input fx_t a, input fx_t b);
        fx2_t w_p;
        w_p = (fx2_t'(a) * fx2_t'(b)) >>> FRAC_BITS;
        return w_p[TOTAL_PREC-1:0];
    endfunction
endpackage

// File: rtl/shade_reflect_pipe_if.sv
// Fragment in/out streams plus light/ambient config port of the reflect pipe.
// Valid/ready on both streams; config is a single-cycle write strobe.
interface shade_reflect_pipe_if #(
    parameter int OUT_BITS = shade_pkg::OUT_BITS_DEF,
    parameter int TAG_W    = shade_pkg::TAG_W_DEF
);
    import shade_pkg::*;

    logic                cfg_we;
    vec3_t               cfg_light;
    fx_t                 cfg_ambient;
    logic                in_valid;
    logic                in_ready;
    vec3_t               tnorm;
    vec3_t               dir;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] res;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output cfg_we, cfg_light, cfg_ambient, in_valid, tnorm, dir, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag
    );
    modport slave (
        input  cfg_we, cfg_light, cfg_ambient, in_valid, tnorm, dir, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag
    );
endinterface

// File: rtl/shade_dot3.sv
// Registered 3-term fixed-point dot product; latency 1 cycle.
// Holds its result while i_en is low.
module shade_dot3
    import shade_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  vec3_t i_a,
    input  vec3_t i_b,
    output fx_t   o_dot
);
    fx_t w_sum;
    fx_t r_dot;

    assign w_sum = fx_mul(i_a[0], i_b[0]) + fx_mul(i_a[1], i_b[1]) + fx_mul(i_a[2], i_b[2]);
    assign o_dot = r_dot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dot <= '0;
        end else if (i_en) begin
            r_dot <= w_sum;
        end
    end
endmodule

// File: rtl/shade_reflect_pipe.sv
// Reflect-vector brightness: res = clamp(ambient + (2(n.L)n - L).d + 1.0); latency 4 cycles.
// Backpressure: whole pipe stalls (bubbles included) while out_valid & !out_ready.
module shade_reflect_pipe
    import shade_pkg::*;
#(
    parameter int OUT_BITS = OUT_BITS_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shade_reflect_pipe_if.slave  bus
);
    logic                w_en;
    vec3_t               r_light;
    fx_t                 r_amb;

    logic                r1_vld, r2_vld, r3_vld, r_out_vld;
    vec3_t               r1_n, r1_d, r1_l, r2_s, r2_d, r2_l;
    fx_t                 r1_amb, r2_amb, r3_amb;
    logic [TAG_W-1:0]    r1_tag, r2_tag, r3_tag, r_out_tag;
    logic [OUT_BITS-1:0] r_res;

    fx_t                 w_k, w_k2, w_p, w_v;
    vec3_t               w_s, w_r;
    logic [OUT_BITS-1:0] w_res;

    assign w_en          = !r_out_vld || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_vld;
    assign bus.res       = r_res;
    assign bus.out_tag   = r_out_tag;

    // Config sampled by S1 on the same edge it is written, so that fragment sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_light <= DEFAULT_LIGHT;
            r_amb   <= '0;
        end else if (bus.cfg_we) begin
            r_light <= bus.cfg_light;
            r_amb   <= bus.cfg_ambient;
        end
    end

    shade_dot3 u_dot_nl (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (bus.tnorm),
        .i_b   (r_light),
        .o_dot (w_k)
    );

    assign w_k2 = w_k <<< 1;

    always_comb begin
        w_s = '0;
        w_r = '0;
        for (int i = 0; i < 3; i++) begin
            w_s[i] = fx_mul(r1_n[i], w_k2);
            w_r[i] = r2_s[i] - r2_l[i];
        end
    end

    shade_dot3 u_dot_rd (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_en),
        .i_a   (w_r),
        .i_b   (r2_d),
        .o_dot (w_p)
    );

    assign w_v = r3_amb + w_p + FX_ONE;

    always_comb begin
        w_res = w_v[FRAC_BITS -: OUT_BITS];
        if (w_v[TOTAL_PREC-1]) begin
            w_res = '0;
        end else if (|w_v[TOTAL_PREC-2:FRAC_BITS+1]) begin
            w_res = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld    <= 1'b0;
            r2_vld    <= 1'b0;
            r3_vld    <= 1'b0;
            r_out_vld <= 1'b0;
            r1_n      <= '0;
            r1_d      <= '0;
            r1_l      <= '0;
            r1_amb    <= '0;
            r1_tag    <= '0;
            r2_s      <= '0;
            r2_d      <= '0;
            r2_l      <= '0;
            r2_amb    <= '0;
            r2_tag    <= '0;
            r3_amb    <= '0;
            r3_tag    <= '0;
            r_res     <= '0;
            r_out_tag <= '0;
        end else if (w_en) begin
            r1_vld    <= bus.in_valid;
            r1_n      <= bus.tnorm;
            r1_d      <= bus.dir;
            r1_l      <= r_light;
            r1_amb    <= r_amb;
            r1_tag    <= bus.in_tag;
            r2_vld    <= r1_vld;
            r2_s      <= w_s;
            r2_d      <= r1_d;
            r2_l      <= r1_l;
            r2_amb    <= r1_amb;
            r2_tag    <= r1_tag;
            r3_vld    <= r2_vld;
            r3_amb    <= r2_amb;
            r3_tag    <= r2_tag;
            r_out_vld <= r3_vld;
            r_res     <= w_res;
            r_out_tag <= r3_tag;
        end
    end
endmodule

// File: tb/tb_shade_reflect_pipe.sv
// Directed-vector bench for shade_reflect_pipe with a tag/result queue and latency tracking.
// Expected brightness values are hand-derived from the reflect formula.
module tb_shade_reflect_pipe;
    import shade_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shade_reflect_pipe_if bus ();

    shade_reflect_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [15:0] tag;
        logic [7:0]  res;
        int          cyc;
    } exp_t;

    int         n_chk = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_out = 0;
    int         out_first = 0;
    int         out_last = 0;
    bit         lat_on = 1'b1;
    logic [7:0] drv_exp = 8'h00;
    exp_t       exp_q[$];
    vec3_t      dpat[3];
    logic [7:0] rpat[3];
    bit         acc;

    localparam fx_t ONE = FX_ONE;

    function automatic vec3_t v3(input fx_t x, input fx_t y, input fx_t z);
        return {z, y, x};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Evaluate both handshakes just before the coming edge, then advance one cycle.
    task automatic step(output bit accepted);
        exp_t e;
        #2;
        accepted = bus.in_valid && bus.in_ready;
        if (accepted) begin
            e.tag = bus.in_tag;
            e.res = drv_exp;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (n_out == 1) out_first = cyc;
            out_last = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(bus.out_tag), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
                chk("res", 32'(bus.res), 32'(e.res));
                if (lat_on) chk("latency", cyc - e.cyc, 4);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input vec3_t n, input vec3_t d, input logic [15:0] tag, input logic [7:0] er);
        bit a;
        a = 1'b0;
        bus.in_valid = 1'b1;
        bus.tnorm    = n;
        bus.dir      = d;
        bus.in_tag   = tag;
        drv_exp      = er;
        for (int i = 0; i < 50; i++) begin
            step(a);
            if (a) break;
        end
        if (!a) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            step(a);
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dpat[0] = v3(0, ONE, 0);  rpat[0] = 8'hFF;
        dpat[1] = v3(ONE, 0, 0);  rpat[1] = 8'h80;
        dpat[2] = v3(0, -ONE, 0); rpat[2] = 8'h00;

        bus.cfg_we      = 1'b0;
        bus.cfg_light   = DEFAULT_LIGHT;
        bus.cfg_ambient = '0;
        bus.in_valid    = 1'b0;
        bus.tnorm       = '0;
        bus.dir         = '0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b1;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_out_tag", 32'(bus.out_tag), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Single fragments under the default +Y light.
        for (int i = 0; i < 3; i++) begin
            send(v3(0, ONE, 0), dpat[i], 16'(16'h0001 + i), rpat[i]);
            bus.in_valid = 1'b0;
            drain();
        end

        // Eight back-to-back fragments.
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            send(v3(0, ONE, 0), dpat[i % 3], 16'(16'h0100 + i), rpat[i % 3]);
        end
        bus.in_valid = 1'b0;
        drain();
        chk("b2b_count", n_out, 8);
        chk("b2b_span", out_last - out_first, 7);

        // Fill the pipe with the consumer stalled, then release.
        lat_on        = 1'b0;
        n_out         = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(v3(0, ONE, 0), dpat[i % 3], 16'(16'h0200 + i), rpat[i % 3]);
        end
        bus.in_valid = 1'b1;
        bus.dir      = dpat[1];
        bus.in_tag   = 16'h0204;
        drv_exp      = rpat[1];
        #1;
        chk("stall_out_valid", 32'(bus.out_valid), 1);
        chk("stall_in_ready", 32'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            chk("stall_hold_tag", 32'(bus.out_tag), 32'h0200);
            chk("stall_hold_res", 32'(bus.res), 32'h00FF);
            chk("stall_in_ready_hold", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        send(v3(0, ONE, 0), dpat[1], 16'h0204, rpat[1]);
        send(v3(0, ONE, 0), dpat[2], 16'h0205, rpat[2]);
        bus.in_valid = 1'b0;
        drain();
        chk("stall_count", n_out, 6);
        lat_on = 1'b1;

        // Config written on the same edge as fragment A: A sees old L=(0,1,0),
        // r=(0,-1,0), p=0, v=1.0 -> 0x80; B sees L=(1,0,0), r=(1,0,0), v=2.0 -> 0xFF.
        bus.cfg_we    = 1'b1;
        bus.cfg_light = v3(ONE, 0, 0);
        send(v3(ONE, 0, 0), v3(ONE, 0, 0), 16'h0300, 8'h80);
        bus.cfg_we = 1'b0;
        send(v3(ONE, 0, 0), v3(ONE, 0, 0), 16'h0301, 8'hFF);
        bus.in_valid = 1'b0;
        drain();

        // Ambient offsets.
        bus.cfg_we      = 1'b1;
        bus.cfg_light   = DEFAULT_LIGHT;
        bus.cfg_ambient = -(ONE <<< 1);
        step(acc);
        bus.cfg_we = 1'b0;
        send(v3(0, ONE, 0), v3(0, ONE, 0), 16'h0400, 8'h00);
        bus.in_valid = 1'b0;
        drain();
        bus.cfg_we      = 1'b1;
        bus.cfg_ambient = ONE >>> 1;
        step(acc);
        bus.cfg_we = 1'b0;
        send(v3(0, ONE, 0), v3(ONE, 0, 0), 16'h0401, 8'hC0);
        bus.in_valid = 1'b0;
        drain();

        // Reset mid-flight with a non-default config loaded.
        bus.cfg_we      = 1'b1;
        bus.cfg_light   = v3(ONE, 0, 0);
        bus.cfg_ambient = -(ONE <<< 1);
        step(acc);
        bus.cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(v3(0, ONE, 0), v3(0, ONE, 0), 16'(16'h0500 + i), 8'h00);
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_res", 32'(bus.res), 0);
        chk("mid_rst_out_tag", 32'(bus.out_tag), 0);
        exp_q.delete();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        n_out = 0;
        for (int i = 0; i < 8; i++) step(acc);
        chk("post_rst_no_out", n_out, 0);
        send(v3(0, ONE, 0), v3(0, ONE, 0), 16'h0600, 8'hFF);
        send(v3(0, ONE, 0), v3(ONE, 0, 0), 16'h0601, 8'h80);
        bus.in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
